// File: rtl/req_encoder_4to2.sv
// Synchronising 4-to-2 request encoder: edge-detected events are latched as pending and
// granted one at a time through a valid/ready output register. Define RR_ARB_EN for round-robin.
module req_encoder_4to2 #(
  parameter int SYNC_STAGES = 2,
  parameter bit PRI_HIGH    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       out_ready,
  input  logic       clr_ovf,
  output logic       out_valid,
  output logic [1:0] code,
  output logic [3:0] pending,
  output logic       ovf
);

  logic [3:0] r_sync [SYNC_STAGES];
  logic [3:0] r_req_d;
  logic [3:0] r_pending;
  logic       r_valid;
  logic [1:0] r_code;
  logic       r_ovf;

  logic [3:0] w_req_s;
  logic [3:0] w_edge;
  logic       w_load;
  logic       w_grant;
  logic [1:0] w_sel;
  logic [3:0] w_grant_vec;
  logic       w_ovf_set;

`ifdef RR_ARB_EN
  logic [1:0] r_ptr;

  // Search starts just after the last granted index and wraps back to it.
  function automatic logic [1:0] f_pick_rr(input logic [3:0] vec, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] cand;
    logic       found;
    idx   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && vec[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction
`else
  function automatic logic [1:0] f_pick_fixed(input logic [3:0] vec);
    logic [1:0] idx;
    idx = 2'd0;
    if (PRI_HIGH) begin
      for (int i = 0; i < 4; i++) begin
        if (vec[i]) idx = 2'(i);
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (vec[i]) idx = 2'(i);
      end
    end
    return idx;
  endfunction
`endif

  // Synchroniser chain for the asynchronous request levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= 4'b0000;
    end else begin
      r_sync[0] <= req;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_req_s = r_sync[SYNC_STAGES-1];
  assign w_edge  = w_req_s & ~r_req_d;

  // Grant selection and overflow detection
  always_comb begin
    w_load      = !r_valid | out_ready;
    w_grant     = w_load & (|r_pending);
`ifdef RR_ARB_EN
    w_sel       = f_pick_rr(r_pending, r_ptr);
`else
    w_sel       = f_pick_fixed(r_pending);
`endif
    w_grant_vec = w_grant ? (4'b0001 << w_sel) : 4'b0000;
    // A fresh edge on a bit leaving pending this cycle re-arms it instead of overflowing.
    w_ovf_set   = |(w_edge & r_pending & ~w_grant_vec);
  end

  // Pending latch, output register and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_d   <= 4'b0000;
      r_pending <= 4'b0000;
      r_valid   <= 1'b0;
      r_code    <= 2'b00;
      r_ovf     <= 1'b0;
    end else begin
      r_req_d   <= w_req_s;
      r_pending <= (r_pending & ~w_grant_vec) | w_edge;
      if (w_load) begin
        if (w_grant) begin
          r_valid <= 1'b1;
          r_code  <= w_sel;
        end else begin
          r_valid <= 1'b0;
        end
      end
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef RR_ARB_EN
  // Round-robin pointer remembers the last granted index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 2'd3;
    end else if (w_grant) begin
      r_ptr <= w_sel;
    end
  end
`endif

  assign out_valid = r_valid;
  assign code      = r_code;
  assign pending   = r_pending;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_req_encoder_4to2.sv
// Scoreboard bench for req_encoder_4to2: expected codes are queued by the stimulus and
// popped by a monitor on every accepted handshake; directed checks cover timing and flags.
module tb_req_encoder_4to2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       out_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       out_valid;
  logic [1:0] code;
  logic [3:0] pending;
  logic       ovf;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q [$];
  logic [1:0] sim_exp [3];

  req_encoder_4to2 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .out_ready (out_ready),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .code      (code),
    .pending   (pending),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  // Monitor: a handshake at the coming posedge must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_grant: got code %0d expected no grant at %0t", code, $time);
      end else begin
        chk("scoreboard_code", {30'd0, code}, {30'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
`ifdef RR_ARB_EN
    sim_exp[0] = 2'd0; sim_exp[1] = 2'd1; sim_exp[2] = 2'd3;
`else
    sim_exp[0] = 2'd3; sim_exp[1] = 2'd1; sim_exp[2] = 2'd0;
`endif
    // Reset / idle
    #2 rst_n = 1'b0;
    #1 chk("reset_outputs", {24'd0, out_valid, code, pending, ovf}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outputs", {24'd0, out_valid, code, pending, ovf}, 32'd0);
    end

    // Single event on req[2], latency of 4 edges, exactly one cycle valid
    out_ready = 1'b1;
    req = 4'b0100;
    exp_q.push_back(2'd2);
    tick(); tick(); tick();
    chk("single_pending", {28'd0, pending}, 32'h4);
    chk("single_not_yet_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("single_valid", {29'd0, out_valid, code}, {29'd0, 1'b1, 2'd2});
    chk("single_pending_cleared", {28'd0, pending}, 32'd0);
    tick();
    chk("single_one_cycle", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("held_level_no_event", {27'd0, out_valid, pending}, 32'd0);
    end

    // Simultaneous events on 1011 from a fresh reset
    do_reset();
    tick(); tick();
    req = 4'b1011;
    exp_q.push_back(sim_exp[0]);
    exp_q.push_back(sim_exp[1]);
    exp_q.push_back(sim_exp[2]);
    tick(); tick(); tick();
    chk("sim_pending", {28'd0, pending}, 32'hB);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sim_grant", {29'd0, out_valid, code}, {29'd0, 1'b1, sim_exp[k]});
    end
    tick();
    chk("sim_drained", {27'd0, out_valid, pending}, 32'd0);

    // Backpressure on req[1]
    req = 4'b0000;
    out_ready = 1'b0;
    tick(); tick(); tick(); tick();
    req = 4'b0010;
    tick(); tick(); tick(); tick();
    chk("bp_loaded", {29'd0, out_valid, code}, {29'd0, 1'b1, 2'd1});
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_frozen", {29'd0, out_valid, code}, {29'd0, 1'b1, 2'd1});
    end
    exp_q.push_back(2'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_accepted", {27'd0, out_valid, pending}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_no_duplicate", {31'd0, out_valid}, 32'd0);
    end

    // Overflow: three pulses on req[0] with the consumer stalled
    out_ready = 1'b0;
    req = 4'b0000;
    tick(); tick(); tick(); tick();
    for (int p = 0; p < 3; p++) begin
      req = 4'b0001;
      tick(); tick(); tick();
      req = 4'b0000;
      tick(); tick(); tick();
      if (p == 1) begin
        chk("ovf_second_pending", {25'd0, out_valid, code, pending, ovf},
            {25'd0, 1'b1, 2'd0, 4'b0001, 1'b0});
      end
    end
    chk("ovf_set", {25'd0, out_valid, code, pending, ovf}, {25'd0, 1'b1, 2'd0, 4'b0001, 1'b1});
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_cleared", {31'd0, ovf}, 32'd0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    out_ready = 1'b1;
    tick();
    chk("ovf_drain_second", {27'd0, out_valid, pending}, {27'd0, 1'b1, 4'b0000});
    tick();
    chk("ovf_drain_done", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-handshake
    out_ready = 1'b0;
    req = 4'b1000;
    tick(); tick(); tick(); tick();
    req = 4'b1110;
    tick(); tick(); tick(); tick();
    chk("pre_reset_state", {27'd0, out_valid, pending}, {27'd0, 1'b1, 4'b0110});
    #2;
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    chk("async_reset_immediate", {24'd0, out_valid, code, pending, ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_reset_quiet", {27'd0, out_valid, pending}, 32'd0);
    end

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
